// File: rtl/cv32e40p_x_coproc_pkg.sv
// Shared types and decode helper for the custom-0 offload coprocessor.
package cv32e40p_x_coproc_pkg;

    localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;

    typedef enum logic [2:0] {
        OpAdd  = 3'd0,
        OpSub  = 3'd1,
        OpMin  = 3'd2,
        OpMaxu = 3'd3,
        OpXor  = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        EntPending   = 2'd0,
        EntCommitted = 2'd1,
        EntKilled    = 2'd2
    } entry_state_e;

    typedef struct packed {
        logic [3:0]   id;
        op_e          op;
        logic [4:0]   rd;
        logic         we;
        logic [31:0]  rs0;
        logic [31:0]  rs1;
        entry_state_e state;
    } entry_t;

    typedef enum logic [1:0] {
        FsmIdle   = 2'd0,
        FsmExec   = 2'd1,
        FsmResult = 2'd2
    } fsm_state_e;

    typedef struct packed {
        logic legal;
        op_e  op;
    } dec_t;

    // Legal only for custom-0 with funct7 == 0 and one of the five funct3 codes.
    function automatic dec_t decode_instr(input logic [6:0] opcode,
                                          input logic [2:0] funct3,
                                          input logic [6:0] funct7);
        dec_t d;
        d.legal = 1'b0;
        d.op    = OpAdd;
        if ((opcode == OPCODE_CUSTOM0) && (funct7 == 7'd0)) begin
            d.legal = 1'b1;
            case (funct3)
                3'b000:  d.op = OpAdd;
                3'b001:  d.op = OpSub;
                3'b010:  d.op = OpMin;
                3'b011:  d.op = OpMaxu;
                3'b100:  d.op = OpXor;
                default: d.legal = 1'b0;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/cv32e40p_x_coproc_if.sv
// CORE-V-XIF issue/commit/result channel bundle between core (master) and coprocessor (slave).
interface cv32e40p_x_coproc_if;

    logic             x_issue_valid;
    logic             x_issue_ready;
    logic [31:0]      x_issue_req_instr;
    logic [3:0]       x_issue_req_id;
    logic [2:0][31:0] x_issue_req_rs;
    logic [2:0]       x_issue_req_rs_valid;
    logic             x_issue_resp_accept;
    logic             x_issue_resp_writeback;
    logic             x_issue_resp_loadstore;

    logic             x_commit_valid;
    logic [3:0]       x_commit_id;
    logic             x_commit_kill;

    logic             x_result_valid;
    logic             x_result_ready;
    logic [3:0]       x_result_id;
    logic [31:0]      x_result_data;
    logic [4:0]       x_result_rd;
    logic             x_result_we;

    modport master (
        output x_issue_valid, x_issue_req_instr, x_issue_req_id, x_issue_req_rs,
               x_issue_req_rs_valid,
        input  x_issue_ready, x_issue_resp_accept, x_issue_resp_writeback,
               x_issue_resp_loadstore,
        output x_commit_valid, x_commit_id, x_commit_kill,
        input  x_result_valid, x_result_id, x_result_data, x_result_rd, x_result_we,
        output x_result_ready
    );

    modport slave (
        input  x_issue_valid, x_issue_req_instr, x_issue_req_id, x_issue_req_rs,
               x_issue_req_rs_valid,
        output x_issue_ready, x_issue_resp_accept, x_issue_resp_writeback,
               x_issue_resp_loadstore,
        input  x_commit_valid, x_commit_id, x_commit_kill,
        output x_result_valid, x_result_id, x_result_data, x_result_rd, x_result_we,
        input  x_result_ready
    );

endinterface

// File: rtl/cv32e40p_x_coproc_alu.sv
// Combinational integer unit for the offloaded custom-0 operations.
module cv32e40p_x_coproc_alu
    import cv32e40p_x_coproc_pkg::*;
(
    input  op_e         op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] result_o
);

    // Select the operation; add/sub wrap naturally at 32 bits.
    always_comb begin
        result_o = '0;
        unique case (op_i)
            OpAdd:   result_o = a_i + b_i;
            OpSub:   result_o = a_i - b_i;
            OpMin:   result_o = ($signed(a_i) < $signed(b_i)) ? a_i : b_i;
            OpMaxu:  result_o = (a_i > b_i) ? a_i : b_i;
            OpXor:   result_o = a_i ^ b_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/cv32e40p_x_coproc.sv
// Coprocessor responder: decodes offloaded custom-0 instructions, buffers them in order
// until commit/kill, then executes committed ones with fixed latency and returns results.
module cv32e40p_x_coproc
    import cv32e40p_x_coproc_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    cv32e40p_x_coproc_if.slave   xif,
    output logic                 busy_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [PtrW:0]   FullCnt   = (PtrW + 1)'(DEPTH);
    localparam logic [PtrW:0]   CntOne    = 1;
    localparam logic [PtrW-1:0] PtrOne    = 1;
    localparam logic [CntW-1:0] LaunchCnt = CntW'(LATENCY - 1);
    localparam logic [CntW-1:0] DecOne    = 1;

    entry_t          buf_q [DEPTH];
    entry_t          buf_d [DEPTH];
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [PtrW:0]   count_q, count_d;
    fsm_state_e      fsm_q, fsm_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            issue_ready;
    logic            handshake;
    logic            push;
    logic            pop;
    dec_t            dec;
    entry_t          head_e;
    entry_state_e    new_state;
    logic [PtrW-1:0] rel [DEPTH];
    logic [DEPTH-1:0] live;
    logic [31:0]     alu_res;
    logic            result_valid;

    // rs1/rs2 register fields and the third operand slot carry nothing this unit needs.
    logic unused_bits;
    assign unused_bits = ^{xif.x_issue_req_instr[24:15], xif.x_issue_req_rs[2],
                           xif.x_issue_req_rs_valid[2]};

    assign dec = decode_instr(xif.x_issue_req_instr[6:0], xif.x_issue_req_instr[14:12],
                              xif.x_issue_req_instr[31:25]);

    // Ready never looks at pop, so a full buffer stays closed even while draining.
    assign issue_ready = (count_q != FullCnt) & xif.x_issue_req_rs_valid[0]
                         & xif.x_issue_req_rs_valid[1];
    assign handshake   = xif.x_issue_valid & issue_ready;
    assign push        = handshake & dec.legal;

    assign xif.x_issue_ready          = issue_ready;
    assign xif.x_issue_resp_accept    = push;
    assign xif.x_issue_resp_writeback = push & (xif.x_issue_req_instr[11:7] != 5'd0);
    assign xif.x_issue_resp_loadstore = 1'b0;

    assign head_e = buf_q[head_q];

    // Mark which slots hold live entries (relative offset from head below count).
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rel[i]  = PtrW'(i) - head_q;
            live[i] = ({1'b0, rel[i]} < count_q);
        end
    end

    // Buffer next state: commit/kill search, tail push, head pop and occupancy.
    always_comb begin
        buf_d     = buf_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        new_state = EntPending;

        if (xif.x_commit_valid) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (live[i] && (buf_q[i].id == xif.x_commit_id)
                    && (buf_q[i].state == EntPending)) begin
                    buf_d[i].state = xif.x_commit_kill ? EntKilled : EntCommitted;
                end
            end
        end

        // A commit for the instruction being issued lands on the new entry directly.
        if (xif.x_commit_valid && (xif.x_commit_id == xif.x_issue_req_id)) begin
            new_state = xif.x_commit_kill ? EntKilled : EntCommitted;
        end

        if (push) begin
            buf_d[tail_q].id    = xif.x_issue_req_id;
            buf_d[tail_q].op    = dec.op;
            buf_d[tail_q].rd    = xif.x_issue_req_instr[11:7];
            buf_d[tail_q].we    = (xif.x_issue_req_instr[11:7] != 5'd0);
            buf_d[tail_q].rs0   = xif.x_issue_req_rs[0];
            buf_d[tail_q].rs1   = xif.x_issue_req_rs[1];
            buf_d[tail_q].state = new_state;
            tail_d              = tail_q + PtrOne;
        end

        if (pop) begin
            head_d = head_q + PtrOne;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    // Execution FSM: drop killed heads, launch committed ones, hold result until accepted.
    always_comb begin
        fsm_d = fsm_q;
        cnt_d = cnt_q;
        pop   = 1'b0;
        unique case (fsm_q)
            FsmIdle: begin
                if (count_q != '0) begin
                    if (head_e.state == EntKilled) begin
                        pop = 1'b1;
                    end else if (head_e.state == EntCommitted) begin
                        if (LATENCY == 1) begin
                            fsm_d = FsmResult;
                        end else begin
                            fsm_d = FsmExec;
                            cnt_d = LaunchCnt;
                        end
                    end
                end
            end
            FsmExec: begin
                cnt_d = cnt_q - DecOne;
                if (cnt_d == '0) begin
                    fsm_d = FsmResult;
                end
            end
            FsmResult: begin
                if (xif.x_result_ready) begin
                    pop   = 1'b1;
                    fsm_d = FsmIdle;
                end
            end
            default: fsm_d = FsmIdle;
        endcase
    end

    cv32e40p_x_coproc_alu u_alu (
        .op_i     (head_e.op),
        .a_i      (head_e.rs0),
        .b_i      (head_e.rs1),
        .result_o (alu_res)
    );

    // Result payload is gated so the channel reads all-zero outside RESULT.
    always_comb begin
        result_valid        = (fsm_q == FsmResult);
        xif.x_result_valid  = result_valid;
        xif.x_result_data   = result_valid ? alu_res : '0;
        xif.x_result_id     = result_valid ? head_e.id : '0;
        xif.x_result_rd     = result_valid ? head_e.rd : '0;
        xif.x_result_we     = result_valid & head_e.we;
    end

    assign busy_o = (count_q != '0) | (fsm_q != FsmIdle);

    // State registers; reset drops buffered entries and any result in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            fsm_q   <= FsmIdle;
            cnt_q   <= '0;
        end else begin
            buf_q   <= buf_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_cv32e40p_x_coproc.sv
// Scoreboard bench: driver pushes expected issue responses and results into queues derived
// from an in-order reference model; a negedge monitor pops and compares on each handshake.
module tb_cv32e40p_x_coproc;

    localparam int DEPTH   = 4;
    localparam int LATENCY = 2;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    cv32e40p_x_coproc_if xif ();

    cv32e40p_x_coproc #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .xif    (xif),
        .busy_o (busy)
    );

    typedef struct {
        logic [3:0]  id;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
        int          st;   // 0 pending, 1 committed, 2 killed
    } mdl_t;

    int        checks = 0;
    int        errors = 0;
    mdl_t      mdl_q[$];
    mdl_t      exp_res_q[$];
    logic [1:0] exp_iss_q[$];
    bit        rand_rdy = 1'b0;
    logic [3:0] next_id = 4'd0;
    logic      stall_q = 1'b0;
    logic [41:0] pay_q = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int f7, input int f3, input int rd,
                                        input logic [6:0] opc);
        logic [6:0] f7v;
        logic [2:0] f3v;
        logic [4:0] rdv;
        f7v = f7[6:0];
        f3v = f3[2:0];
        rdv = rd[4:0];
        return {f7v, 5'd2, 5'd1, f3v, rdv, opc};
    endfunction

    function automatic bit ref_legal(input logic [31:0] ins);
        return (ins[6:0] == 7'h0B) && (ins[31:25] == 7'd0) && (ins[14:12] <= 3'd4);
    endfunction

    function automatic logic [31:0] ref_res(input logic [31:0] ins, input logic [31:0] a,
                                            input logic [31:0] b);
        case (ins[14:12])
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return ($signed(a) < $signed(b)) ? a : b;
            3'd3:    return (a > b) ? a : b;
            default: return a ^ b;
        endcase
    endfunction

    // Results leave strictly in issue order; the front waits while still pending.
    task automatic drain_model();
        while (mdl_q.size() > 0 && mdl_q[0].st != 0) begin
            if (mdl_q[0].st == 1) exp_res_q.push_back(mdl_q[0]);
            void'(mdl_q.pop_front());
        end
    endtask

    task automatic model_commit(input logic [3:0] id, input bit kill);
        foreach (mdl_q[i]) begin
            if (mdl_q[i].id == id && mdl_q[i].st == 0) mdl_q[i].st = kill ? 2 : 1;
        end
        drain_model();
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] id, input bit do_commit, input bit kill);
        bit   acc;
        int   n;
        mdl_t e;
        acc = ref_legal(ins);
        exp_iss_q.push_back({acc, acc && (ins[11:7] != 5'd0)});
        @(posedge clk);
        #1;
        xif.x_issue_valid        = 1'b1;
        xif.x_issue_req_instr    = ins;
        xif.x_issue_req_id       = id;
        xif.x_issue_req_rs[0]    = a;
        xif.x_issue_req_rs[1]    = b;
        xif.x_issue_req_rs[2]    = $urandom;
        xif.x_issue_req_rs_valid = 3'b111;
        xif.x_commit_valid       = do_commit;
        xif.x_commit_id          = id;
        xif.x_commit_kill        = kill;
        n = 0;
        @(negedge clk);
        while (!xif.x_issue_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got ready=0 for 100 cycles expected ready=1");
            void'(exp_iss_q.pop_back());
            @(posedge clk);
        end else begin
            @(posedge clk);
            if (acc) begin
                e.id  = id;
                e.res = ref_res(ins, a, b);
                e.rd  = ins[11:7];
                e.we  = (ins[11:7] != 5'd0);
                e.st  = do_commit ? (kill ? 2 : 1) : 0;
                mdl_q.push_back(e);
                drain_model();
            end
        end
        #1;
        xif.x_issue_valid  = 1'b0;
        xif.x_commit_valid = 1'b0;
        xif.x_commit_kill  = 1'b0;
    endtask

    task automatic commit(input logic [3:0] id, input bit kill);
        @(posedge clk);
        #1;
        xif.x_commit_valid = 1'b1;
        xif.x_commit_id    = id;
        xif.x_commit_kill  = kill;
        @(posedge clk);
        model_commit(id, kill);
        #1;
        xif.x_commit_valid = 1'b0;
        xif.x_commit_kill  = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((busy || exp_res_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_pending"}, exp_res_q.size(), 0);
    endtask

    // Monitor: compares issue responses and results on handshakes, and result hold under stall.
    always @(negedge clk) begin
        mdl_t       e;
        logic [1:0] ei;
        if (!rst_ni) begin
            stall_q <= 1'b0;
        end else begin
            if (stall_q) begin
                chk("result_hold", {xif.x_result_valid, xif.x_result_id, xif.x_result_data,
                    xif.x_result_rd, xif.x_result_we}, {1'b1, pay_q});
            end
            if (xif.x_issue_valid && xif.x_issue_ready) begin
                if (exp_iss_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL issue_unexpected: got handshake id=%0d expected none",
                             xif.x_issue_req_id);
                end else begin
                    ei = exp_iss_q.pop_front();
                    chk("issue_resp", {xif.x_issue_resp_accept, xif.x_issue_resp_writeback,
                        xif.x_issue_resp_loadstore}, {ei, 1'b0});
                end
            end
            if (xif.x_result_valid && xif.x_result_ready) begin
                if (exp_res_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL result_unexpected: got id=%0d data=%0h expected none",
                             xif.x_result_id, xif.x_result_data);
                end else begin
                    e = exp_res_q.pop_front();
                    chk("result", {xif.x_result_id, xif.x_result_data, xif.x_result_rd,
                        xif.x_result_we}, {e.id, e.res, e.rd, e.we});
                end
            end
            stall_q <= xif.x_result_valid && !xif.x_result_ready;
            pay_q   <= {xif.x_result_id, xif.x_result_data, xif.x_result_rd, xif.x_result_we};
        end
    end

    // Random result backpressure during the random phase.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_rdy) xif.x_result_ready = ($urandom_range(3) != 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic [41:0] pay;
        logic [31:0] ins, a, b;
        int   f7, r;
        bit   found;

        xif.x_issue_valid        = 1'b0;
        xif.x_issue_req_instr    = '0;
        xif.x_issue_req_id       = '0;
        xif.x_issue_req_rs       = '0;
        xif.x_issue_req_rs_valid = 3'b111;
        xif.x_commit_valid       = 1'b0;
        xif.x_commit_id          = '0;
        xif.x_commit_kill        = 1'b0;
        xif.x_result_ready       = 1'b1;

        // Reset values.
        #12;
        chk("rst_outputs", {xif.x_result_valid, busy, xif.x_issue_resp_accept,
            xif.x_issue_resp_writeback, xif.x_issue_resp_loadstore, xif.x_result_data,
            xif.x_result_id, xif.x_result_rd, xif.x_result_we}, 0);
        chk("rst_ready", xif.x_issue_ready, 1);
        xif.x_issue_req_rs_valid = 3'b101;
        #1;
        chk("rst_ready_rsinvalid", xif.x_issue_ready, 0);
        xif.x_issue_req_rs_valid = 3'b111;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // ADD with same-cycle commit, and first-result latency.
        issue(32'h0020818B, 32'd5, 32'd7, 4'd2, 1'b1, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!xif.x_result_valid && n < 20);
        chk("add_latency", n, LATENCY + 1);
        wait_idle("add");

        // Illegal encoding: rejected, nothing buffered.
        issue(enc(0, 7, 3, 7'h0B), 32'd1, 32'd2, 4'd3, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        chk("illegal_busy", busy, 0);

        // Kill the middle of three.
        issue(enc(0, 1, 4, 7'h0B), 32'd0, 32'd1, 4'd0, 1'b0, 1'b0);
        issue(enc(0, 2, 5, 7'h0B), 32'hFFFF_FFF0, 32'd3, 4'd1, 1'b0, 1'b0);
        issue(enc(0, 4, 6, 7'h0B), 32'hF0F0_1234, 32'h0FF0_0000, 4'd2, 1'b0, 1'b0);
        chk("kill_first_val", exp_res_q.size(), 0);
        commit(4'd1, 1'b1);
        commit(4'd0, 1'b0);
        commit(4'd2, 1'b0);
        wait_idle("kill");

        // Full buffer: ready low on the fifth, high again only after a pop.
        for (int i = 0; i < 4; i++) issue(enc(0, 0, 7, 7'h0B), i, 32'd1, 4'(4 + i), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        xif.x_issue_valid     = 1'b1;
        xif.x_issue_req_instr = enc(0, 0, 8, 7'h0B);
        xif.x_issue_req_id    = 4'd8;
        @(negedge clk);
        chk("full_ready", xif.x_issue_ready, 0);
        chk("full_busy", busy, 1);
        @(posedge clk);
        #1;
        xif.x_issue_valid = 1'b0;
        commit(4'd4, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(xif.x_result_valid && xif.x_result_ready) && n < 20);
        chk("full_ready_at_pop", xif.x_issue_ready, 0);
        @(negedge clk);
        chk("full_ready_after_pop", xif.x_issue_ready, 1);
        commit(4'd5, 1'b0);
        commit(4'd6, 1'b1);
        commit(4'd7, 1'b0);
        wait_idle("full");

        // Backpressure: result held stable for five cycles, then exactly one pop.
        @(posedge clk);
        #1;
        xif.x_result_ready = 1'b0;
        issue(enc(0, 3, 9, 7'h0B), 32'h8000_0000, 32'h7FFF_FFFF, 4'd9, 1'b1, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!xif.x_result_valid && n < 20);
        pay = {xif.x_result_id, xif.x_result_data, xif.x_result_rd, xif.x_result_we};
        chk("bp_payload", pay, {4'd9, 32'h8000_0000, 5'd9, 1'b1});
        repeat (5) begin
            @(negedge clk);
            chk("bp_stable", {xif.x_result_valid, xif.x_result_id, xif.x_result_data,
                xif.x_result_rd, xif.x_result_we}, {1'b1, pay});
        end
        @(posedge clk);
        #1;
        xif.x_result_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_single_pop", {xif.x_result_valid, busy}, 0);

        // Reset while the head is executing with three entries buffered.
        issue(enc(0, 0, 10, 7'h0B), 32'd1, 32'd1, 4'd10, 1'b0, 1'b0);
        issue(enc(0, 0, 11, 7'h0B), 32'd2, 32'd2, 4'd11, 1'b0, 1'b0);
        issue(enc(0, 0, 12, 7'h0B), 32'd3, 32'd3, 4'd12, 1'b0, 1'b0);
        commit(4'd10, 1'b0);
        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_valid", xif.x_result_valid, 0);
        mdl_q.delete();
        exp_res_q.delete();
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        issue(enc(0, 1, 13, 7'h0B), 32'd100, 32'd58, 4'd13, 1'b1, 1'b0);
        wait_idle("rst_reissue");

        // Random phase.
        next_id = 4'd0;
        rand_rdy = 1'b1;
        for (int it = 0; it < 200; it++) begin
            r = $urandom_range(9);
            if (r <= 5) begin
                if (mdl_q.size() < DEPTH) begin
                    f7  = ($urandom_range(7) == 0) ? $urandom_range(127, 1) : 0;
                    ins = enc(f7, $urandom_range(7), $urandom_range(31),
                              ($urandom_range(7) == 0) ? 7'h33 : 7'h0B);
                    a   = ($urandom_range(3) == 0) ? 32'h8000_0000 : $urandom;
                    b   = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom;
                    issue(ins, a, b, next_id, $urandom_range(2) == 0, $urandom_range(3) == 0);
                    next_id = next_id + 4'd1;
                end
            end else if (r <= 8) begin
                found = 1'b0;
                if (mdl_q.size() > 0) begin
                    n = $urandom_range(mdl_q.size() - 1);
                    if (mdl_q[n].st == 0) begin
                        commit(mdl_q[n].id, $urandom_range(3) == 0);
                        found = 1'b1;
                    end
                end
                if (!found) commit(4'($urandom_range(15)), $urandom_range(1) == 1);
            end else begin
                @(posedge clk);
                #1;
                xif.x_issue_valid        = 1'b1;
                xif.x_issue_req_rs_valid = ($urandom_range(1) == 1) ? 3'b101 : 3'b110;
                @(negedge clk);
                chk("rs_invalid_ready", xif.x_issue_ready, 0);
                @(posedge clk);
                #1;
                xif.x_issue_valid        = 1'b0;
                xif.x_issue_req_rs_valid = 3'b111;
            end
        end
        while (mdl_q.size() > 0) commit(mdl_q[0].id, 1'b0);
        @(posedge clk);
        #1;
        rand_rdy = 1'b0;
        xif.x_result_ready = 1'b1;
        wait_idle("random");
        chk("scoreboard_empty", exp_res_q.size() + exp_iss_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cv32e40p_x_coproc.md
# cv32e40p_x_coproc

Coprocessor-side responder for the CORE-V-XIF issue, commit and result channels used by the cv32e40p offload dispatcher. It decodes offloaded custom-0 instructions and accepts or rejects them in the issue handshake cycle. Accepted instructions are buffered in order until the core commits or kills them. Committed instructions run on a fixed-latency integer unit, and results return on the result channel with rd, we and id.

## Interface
- DEPTH, 4: instruction buffer entries; power of 2, ≥2.
- LATENCY, 2: execution latency in cycles; ≥1.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- x_issue_valid_i  in  1  issue request valid.
- x_issue_ready_o  out  1  issue request ready.
- x_issue_req_instr_i  in  32  offloaded instruction word.
- x_issue_req_id_i  in  4  instruction id.
- x_issue_req_rs_i  in  3×32  source operands; only rs[0] and rs[1] are used.
- x_issue_req_rs_valid_i  in  3  operand valid; only bits 0 and 1 are used.
- x_issue_resp_accept_o  out  1  instruction accepted.
- x_issue_resp_writeback_o  out  1  a result with we=1 will follow.
- x_issue_resp_loadstore_o  out  1  tied to 0.
- x_commit_valid_i  in  1  commit valid.
- x_commit_id_i  in  4  id being committed or killed.
- x_commit_kill_i  in  1  kill the instruction instead of committing it.
- x_result_valid_o  out  1  result valid.
- x_result_ready_i  in  1  result ready.
- x_result_id_o  out  4  result id.
- x_result_data_o  out  32  result data.
- x_result_rd_o  out  5  destination register.
- x_result_we_o  out  1  register write enable.
- busy_o  out  1  buffer not empty or FSM not IDLE.

## Operation
- Decode: opcode == 7'b0001011 and funct7 == 0 are required.
  - funct3 selects the operation: 000 ADD, 001 SUB, 010 MIN (signed), 011 MAXU, 100 XOR.
  - Any other encoding is not accepted.
- Issue handshake: the cycle where x_issue_valid_i & x_issue_ready_o are both high.
  - x_issue_ready_o = (count != DEPTH) & rs_valid[0] & rs_valid[1].
  - Response outputs are combinational and valid only during the handshake cycle.
  - accept = decode legal.
  - writeback = accept & (rd != 0).
- Rejected instruction: handshake completes with accept=0 and no entry is written.
- Accepted instruction: pushed at the tail.
  - Entry fields: id, op, rd, we, rs0, rs1, state.
  - New entries start in state PENDING.
- Commit: x_commit_valid_i searches the valid entries for x_commit_id_i, including the entry being pushed in the same cycle.
  - On a match the entry becomes KILLED if x_commit_kill_i, else COMMITTED.
  - An id with no matching entry is ignored.
  - A commit for an entry that is not PENDING is ignored.
- Execution FSM, in order from the head entry:
  - IDLE: if head is KILLED, pop it (one per cycle). If head is COMMITTED, launch: go to EXEC, or straight to RESULT when LATENCY=1. If head is PENDING, wait.
  - EXEC: countdown from LATENCY-1; move to RESULT when the count reaches 0.
  - RESULT: x_result_valid_o=1 with data computed from the head entry, we = entry we, rd, id.
  - On x_result_valid_o & x_result_ready_i: pop the head and return to IDLE.
- Result emission: every COMMITTED instruction produces exactly one result, including we=0.
- Arithmetic: 32-bit two's complement; ADD and SUB wrap modulo 2^32.
- Boundary conditions:
  - Push and pop in the same cycle: count unchanged.
  - Buffer full: ready stays low even while a pop occurs in that cycle; ready does not depend on pop.
  - Pointers wrap modulo DEPTH.
  - The head is not popped while in EXEC or RESULT, whatever kill arrives.
  - A kill aimed at an already launched entry is ignored.

## Timing
- Reset values: x_result_valid_o=0, busy_o=0, all outputs 0.
  - Exception: x_issue_ready_o = rs_valid[0] & rs_valid[1] while the buffer is empty.
- Buffer, FSM, countdown and state fields are registered.
- Issue response and ready are combinational from inputs and count.
- Latency: issue and commit in cycle 0 with the unit idle puts x_result_valid_o high in cycle LATENCY+1.
- Result hold: x_result_valid_o and the result payload stay stable until x_result_ready_i.
- Throughput: one result per LATENCY+1 cycles when ready is held high.
- Reset mid-operation: buffer emptied, FSM returned to IDLE, any result in flight dropped.

## Structure
- Package cv32e40p_x_coproc_pkg holds:
  - OPCODE_CUSTOM0 constant.
  - op_e enum (ADD, SUB, MIN, MAXU, XOR).
  - entry_state_e enum (PENDING, COMMITTED, KILLED).
  - entry_t struct.
  - fsm_state_e enum (IDLE, EXEC, RESULT).
- Sub-module cv32e40p_x_coproc_alu: combinational, op_e plus two 32-bit operands in, 32-bit result out.
- Decoder, buffer and FSM live in the top module.

## Test plan
- ADD accepted and committed: instr 0x0020818B (ADD, rd=3, rs=1,2), rs0=5, rs1=7, id=2, commit id=2 in the same cycle -> accept=1, writeback=1; cycle 3: result valid, data=12, rd=3, we=1, id=2.
- Illegal encoding: funct3=111 -> handshake completes with accept=0, writeback=0; busy_o stays 0; no result.
- Kill: issue ids 0, 1, 2 (SUB 0-1, MIN, XOR); kill id 1, commit ids 0 and 2 -> results only for id 0 (data 0xFFFFFFFF) and id 2, in order.
- Full buffer: 4 issues without commit -> x_issue_ready_o=0 on the 5th request; one commit plus result handshake -> ready returns high the cycle after the pop.
- Backpressure: hold x_result_ready_i=0 for 5 cycles -> valid and payload stay stable; on release, a single pop.
- Reset asserted in EXEC with 3 entries buffered -> busy_o=0 and x_result_valid_o=0 immediately; re-issue after reset works.
